// File: rtl/param_imem.sv
// ---------------------------------------------------------------------------
// param_imem: instruction memory with a single-outstanding fetch port, a
// fixed, parameterised response latency and a loader write port.
//
// Parameters
//   DATA_W  : instruction word width
//   ADDR_W  : byte-address width (must exceed log2(DEPTH)+2)
//   DEPTH   : number of words, power of two, 2..4096
//   LATENCY : cycles from request acceptance to response valid, 1..8
//
// Ports
//   clk_i, rst_i           : clock, synchronous active-high reset
//   req_valid_i/ready_o    : fetch request handshake, req_addr_i byte address
//   rsp_valid_o/ready_i    : response handshake, rsp_data_o word, rsp_fault_o
//   wr_en_i/addr_i/data_i  : loader write port, active in every FSM state
//
// Build option
//   TARTARUGA_IMEM_MISALIGN_FAULT_EN : when defined, a request whose address
//   is not word aligned returns rsp_fault_o = 1 with zero data. When not
//   defined, the two low address bits are ignored and rsp_fault_o is 0.
// ---------------------------------------------------------------------------
module param_imem #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_fault_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_data;
    logic               w_accept;
    logic               w_resp;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [DATA_W-1:0]  w_rd_word;
    logic               w_unused;

    // Power-of-two depth: dropping the upper index bits is the modulo wrap.
    assign w_rd_idx = req_addr_i[IDX_W+1:2];
    assign w_wr_idx = wr_addr_i[IDX_W+1:2];
    assign w_accept = req_valid_i & req_ready_o;

`ifdef TARTARUGA_IMEM_MISALIGN_FAULT_EN
    logic r_fault;
    logic w_misalign;

    assign w_misalign = |req_addr_i[1:0];
    assign w_rd_word  = w_misalign ? '0 : r_mem[w_rd_idx];
    assign w_unused   = ^{req_addr_i[ADDR_W-1:IDX_W+2], wr_addr_i[ADDR_W-1:IDX_W+2],
                          wr_addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_fault <= w_misalign;
        end
    end
`else
    assign w_rd_word = r_mem[w_rd_idx];
    assign w_unused  = ^{req_addr_i[ADDR_W-1:IDX_W+2], req_addr_i[1:0],
                         wr_addr_i[ADDR_W-1:IDX_W+2], wr_addr_i[1:0]};
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                // Last wait cycle is the one where the counter steps 1 -> 0.
                if ((r_cnt == CNT_ONE) || (r_cnt == '0)) begin
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Latency counter and response snapshot. The snapshot reads the array
    // before this edge's write lands, so a same-cycle write returns old data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_cnt  <= CNT_W'(LATENCY - 1);
            r_data <= w_rd_word;
        end else if ((r_state == StWait) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Storage: reset loads word i with i; loader writes in any state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(i);
            end
        end else if (wr_en_i) begin
            r_mem[w_wr_idx] <= wr_data_i;
        end
    end

    // Outputs
    assign w_resp = (r_state == StResp);

    always_comb begin
        req_ready_o = (r_state == StIdle);
        rsp_valid_o = w_resp;
        rsp_data_o  = w_resp ? r_data : '0;
`ifdef TARTARUGA_IMEM_MISALIGN_FAULT_EN
        rsp_fault_o = w_resp & r_fault;
`else
        rsp_fault_o = 1'b0;
`endif
    end

endmodule
